// File: rtl/button_events_if.sv
// Pin-side bundle for button_events: raw active-low buttons in, conditioned
// levels, event pulses and the heartbeat out.
interface button_events_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] buttons_n;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] long_pulse;
  logic [CHANNELS-1:0] repeat_pulse;
  logic                heartbeat;

  modport master (
    output buttons_n,
    input  level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  heartbeat
  );

  modport slave (
    input  buttons_n,
    output level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output repeat_pulse,
    output heartbeat
  );
endinterface

// File: rtl/button_events.sv
// Push-button conditioner: per-channel 2-FF sync, debounce, hold FSM with
// press/release/long/repeat pulses, plus a free-running heartbeat toggle.
module button_events_chk #(
  parameter int CHANNELS = 4
) (
  input logic                clock,
  input logic                reset_n,
  input logic [CHANNELS-1:0] level_i,
  input logic [CHANNELS-1:0] press_i,
  input logic [CHANNELS-1:0] release_i,
  input logic [CHANNELS-1:0] long_i,
  input logic [CHANNELS-1:0] repeat_i
);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chk
    a_one_event: assert property (@(posedge clock) disable iff (!reset_n)
      $onehot0({press_i[g], release_i[g], long_i[g], repeat_i[g]}));
    a_press_level: assert property (@(posedge clock) disable iff (!reset_n)
      press_i[g] |-> level_i[g]);
    a_release_level: assert property (@(posedge clock) disable iff (!reset_n)
      release_i[g] |-> !level_i[g]);
  end
endmodule

module button_events #(
  parameter int CHANNELS         = 4,
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int LONG_CYCLES      = 50000000,
  parameter int REPEAT_EN        = 1,
  parameter int REPEAT_CYCLES    = 12500000,
  parameter int HEARTBEAT_CYCLES = 25000000
) (
  input logic            clock,
  input logic            reset_n,
  button_events_if.slave bus
);
  localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam int HB_W     = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HEARTBEAT_CYCLES - 1);
  localparam logic              REPEAT_ON = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HELD = 2'b01,
    ST_LONG = 2'b10
  } hold_state_e;

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] btn_s;
  logic [CHANNELS-1:0] level_s;
  logic [CHANNELS-1:0] press_s;
  logic [CHANNELS-1:0] release_s;
  logic [CHANNELS-1:0] long_s;
  logic [CHANNELS-1:0] repeat_s;

  logic [HB_W-1:0] hb_cnt_q;
  logic [HB_W-1:0] hb_cnt_d;
  logic            hb_q;
  logic            hb_d;

  // Two-stage synchroniser; reset to "released" so a held button reads as a press later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.buttons_n;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = ~sync2_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic              stable_q;
    logic              stable_d;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DB_W-1:0]   db_cnt_d;
    logic              flip_s;
    logic              rise_s;
    logic              fall_s;
    hold_state_e       state_q;
    hold_state_e       state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              press_q;
    logic              press_d;
    logic              release_q;
    logic              release_d;
    logic              long_q;
    logic              long_d;
    logic              repeat_q;
    logic              repeat_d;

    // Debounce next state: a new level must persist DEBOUNCE_CYCLES cycles.
    always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      flip_s   = 1'b0;
      if (btn_s[g] == stable_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        stable_d = btn_s[g];
        db_cnt_d = '0;
        flip_s   = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    // Debounce state register.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        stable_q <= 1'b0;
        db_cnt_q <= '0;
      end else begin
        stable_q <= stable_d;
        db_cnt_q <= db_cnt_d;
      end
    end

    assign rise_s = flip_s & stable_d;
    assign fall_s = flip_s & ~stable_d;

    // Hold FSM next state; a release always wins over a threshold hit.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
        ST_IDLE: begin
          if (rise_s) begin
            state_d    = ST_HELD;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
        end
        ST_HELD: begin
          if (fall_s) begin
            state_d = ST_IDLE;
          end else if (hold_cnt_q == LONG_LAST) begin
            state_d    = ST_LONG;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          if (fall_s) begin
            state_d = ST_IDLE;
          end else if (!REPEAT_ON) begin
            hold_cnt_d = hold_cnt_q;
          end else if (hold_cnt_q == REP_LAST) begin
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        default: begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end

    // Hold FSM pulse decode, registered below so pulses align with level.
    always_comb begin
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          press_d = rise_s;
        end
        ST_HELD: begin
          release_d = fall_s;
          long_d    = ~fall_s & (hold_cnt_q == LONG_LAST);
        end
        ST_LONG: begin
          release_d = fall_s;
          repeat_d  = ~fall_s & REPEAT_ON & (hold_cnt_q == REP_LAST);
        end
        default: begin
          press_d = 1'b0;
        end
      endcase
    end

    // Hold FSM state, counter and pulse registers.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q    <= ST_IDLE;
        hold_cnt_q <= '0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
        repeat_q   <= 1'b0;
      end else begin
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        press_q    <= press_d;
        release_q  <= release_d;
        long_q     <= long_d;
        repeat_q   <= repeat_d;
      end
    end

    assign level_s[g]   = stable_q;
    assign press_s[g]   = press_q;
    assign release_s[g] = release_q;
    assign long_s[g]    = long_q;
    assign repeat_s[g]  = repeat_q;
  end

  // Heartbeat divider next state.
  always_comb begin
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end else begin
      hb_cnt_d = hb_cnt_q + HB_W'(1);
      hb_d     = hb_q;
    end
  end

  // Heartbeat register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

  assign bus.level         = level_s;
  assign bus.press_pulse   = press_s;
  assign bus.release_pulse = release_s;
  assign bus.long_pulse    = long_s;
  assign bus.repeat_pulse  = repeat_s;
  assign bus.heartbeat     = hb_q;

  button_events_chk #(.CHANNELS(CHANNELS)) u_chk (
    .clock     (clock),
    .reset_n   (reset_n),
    .level_i   (level_s),
    .press_i   (press_s),
    .release_i (release_s),
    .long_i    (long_s),
    .repeat_i  (repeat_s)
  );
endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: expected events are queued with their due cycle
// when stimulus is driven and matched against every output on each cycle.
module tb_button_events;
  localparam int CH  = 4;
  localparam int DB  = 4;
  localparam int LG  = 20;
  localparam int RP  = 8;
  localparam int HB  = 5;
  localparam int LAT = 2 + DB;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_LONG    = 2;
  localparam int EV_REPEAT  = 3;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH-1:0] btn_n   = 4'b1111;

  button_events_if #(.CHANNELS(CH)) bus0 ();
  button_events_if #(.CHANNELS(CH)) bus1 ();
  assign bus0.buttons_n = btn_n;
  assign bus1.buttons_n = btn_n;

  button_events #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .REPEAT_EN(1),
                  .REPEAT_CYCLES(RP), .HEARTBEAT_CYCLES(HB)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0));

  button_events #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .REPEAT_EN(0),
                  .REPEAT_CYCLES(RP), .HEARTBEAT_CYCLES(HB)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int at;
    int kind;
    int ch;
  } ev_t;

  ev_t sb[$];
  int  vectors     = 0;
  int  miscompares = 0;
  bit  mon_en      = 1'b0;
  int  rel_cyc     = 0;

  logic [CH-1:0] exp_level = 4'b0000;
  logic [CH-1:0] e_pr, e_rl, e_lg, e_rp;
  logic          e_hb;

  function automatic void expect_ev(int at, int kind, int ch);
    ev_t e;
    e.at   = at;
    e.kind = kind;
    e.ch   = ch;
    sb.push_back(e);
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Scoreboard: pop events due this cycle and compare every output of dut0.
  always @(negedge clock) begin
    if (mon_en) begin
      e_pr = 4'b0000;
      e_rl = 4'b0000;
      e_lg = 4'b0000;
      e_rp = 4'b0000;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at == cyc) begin
          case (sb[i].kind)
            EV_PRESS:   e_pr[sb[i].ch] = 1'b1;
            EV_RELEASE: e_rl[sb[i].ch] = 1'b1;
            EV_LONG:    e_lg[sb[i].ch] = 1'b1;
            default:    e_rp[sb[i].ch] = 1'b1;
          endcase
          sb.delete(i);
        end else if (sb[i].at < cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL stale_event ch%0d kind%0d due %0d now %0d", sb[i].ch, sb[i].kind, sb[i].at, cyc);
          sb.delete(i);
        end
      end
      exp_level = (exp_level | e_pr) & ~e_rl;
      if (!reset_n) exp_level = 4'b0000;
      e_hb = reset_n ? ((((cyc - rel_cyc) / HB) % 2) == 1) : 1'b0;
      vectors++;
      if ({bus0.level, bus0.press_pulse, bus0.release_pulse, bus0.long_pulse,
           bus0.repeat_pulse, bus0.heartbeat} !==
          {exp_level, e_pr, e_rl, e_lg, e_rp, e_hb}) begin
        miscompares++;
        $display("FAIL outputs cyc%0d got lvl=%b pr=%b rl=%b lg=%b rp=%b hb=%b want lvl=%b pr=%b rl=%b lg=%b rp=%b hb=%b",
                 cyc, bus0.level, bus0.press_pulse, bus0.release_pulse, bus0.long_pulse,
                 bus0.repeat_pulse, bus0.heartbeat, exp_level, e_pr, e_rl, e_lg, e_rp, e_hb);
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    btn_n   = 4'b1111;
    mon_en  = 1'b1;
    step(3);
    vectors++;
    if ({bus0.level, bus0.press_pulse, bus0.release_pulse, bus0.long_pulse,
         bus0.repeat_pulse, bus0.heartbeat} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got lvl=%b pr=%b hb=%b want all 0", bus0.level, bus0.press_pulse, bus0.heartbeat);
    end
    reset_n = 1'b1;
    rel_cyc = cyc;
    step(12);
  endtask

  task automatic test_clean_press();
    int t0;
    t0 = cyc;
    btn_n[0] = 1'b0;
    expect_ev(t0 + LAT, EV_PRESS, 0);
    step(LAT);
    vectors++;
    if (bus0.press_pulse !== 4'b0001 || bus0.level !== 4'b0001) begin
      miscompares++;
      $display("FAIL clean_press got pr=%b lvl=%b want 0001/0001", bus0.press_pulse, bus0.level);
    end
    step(10 - LAT);
    btn_n[0] = 1'b1;
    expect_ev(t0 + 10 + LAT, EV_RELEASE, 0);
    step(LAT);
    vectors++;
    if (bus0.release_pulse !== 4'b0001 || bus0.level !== 4'b0000) begin
      miscompares++;
      $display("FAIL clean_release got rl=%b lvl=%b want 0001/0000", bus0.release_pulse, bus0.level);
    end
    step(30);
  endtask

  task automatic test_bounce();
    int tf;
    for (int k = 0; k < 10; k++) begin
      btn_n[1] = (k % 2 == 1);
      step(3);
    end
    btn_n[1] = 1'b0;
    tf = cyc;
    expect_ev(tf + LAT, EV_PRESS, 1);
    step(LAT);
    vectors++;
    if (bus0.press_pulse !== 4'b0010) begin
      miscompares++;
      $display("FAIL bounce_press got pr=%b want 0010", bus0.press_pulse);
    end
    step(9);
    btn_n[1] = 1'b1;
    expect_ev(cyc + LAT, EV_RELEASE, 1);
    step(12);
  endtask

  task automatic test_long_repeat();
    int t0, p, long1_n, long1_at, rep1_n;
    long1_n  = 0;
    long1_at = -1;
    rep1_n   = 0;
    t0 = cyc;
    p  = t0 + LAT;
    btn_n[2] = 1'b0;
    expect_ev(p, EV_PRESS, 2);
    expect_ev(p + LG, EV_LONG, 2);
    for (int r = 1; r <= 5; r++) expect_ev(p + LG + r * RP, EV_REPEAT, 2);
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (cyc == p + 57) begin
        btn_n[2] = 1'b1;
        expect_ev(p + 57 + LAT, EV_RELEASE, 2);
      end
      if (bus1.long_pulse[2] === 1'b1) begin
        long1_n++;
        long1_at = cyc;
      end
      if (bus1.repeat_pulse !== 4'b0000) rep1_n++;
    end
    step(1);
    vectors++;
    if (rep1_n !== 0) begin
      miscompares++;
      $display("FAIL norepeat_count got %0d want 0", rep1_n);
    end
    vectors++;
    if (long1_n !== 1 || long1_at !== p + LG) begin
      miscompares++;
      $display("FAIL norepeat_long got n=%0d at=%0d want n=1 at=%0d", long1_n, long1_at, p + LG);
    end
  endtask

  task automatic test_collision();
    int p;
    p = cyc + LAT;
    btn_n[3] = 1'b0;
    expect_ev(p, EV_PRESS, 3);
    step(LAT + LG - LAT);
    btn_n[3] = 1'b1;
    expect_ev(p + LG, EV_RELEASE, 3);
    step(LAT);
    vectors++;
    if (bus0.release_pulse !== 4'b1000 || bus0.long_pulse !== 4'b0000) begin
      miscompares++;
      $display("FAIL collision got rl=%b lg=%b want 1000/0000", bus0.release_pulse, bus0.long_pulse);
    end
    step(30);
  endtask

  task automatic test_reset_mid_hold();
    int p;
    p = cyc + LAT;
    btn_n[0] = 1'b0;
    expect_ev(p, EV_PRESS, 0);
    expect_ev(p + LG, EV_LONG, 0);
    expect_ev(p + LG + RP, EV_REPEAT, 0);
    expect_ev(p + LG + 2 * RP, EV_REPEAT, 0);
    step(LAT + 40);
    reset_n = 1'b0;
    step(2);
    vectors++;
    if ({bus0.level, bus0.press_pulse, bus0.release_pulse, bus0.long_pulse, bus0.repeat_pulse,
         bus1.level, bus1.release_pulse} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_mid_hold got lvl=%b rl=%b want 0", bus0.level, bus0.release_pulse);
    end
    step(3);
    reset_n = 1'b1;
    rel_cyc = cyc;
    expect_ev(cyc + LAT, EV_PRESS, 0);
    step(LAT);
    vectors++;
    if (bus0.press_pulse !== 4'b0001) begin
      miscompares++;
      $display("FAIL held_through_reset got pr=%b want 0001", bus0.press_pulse);
    end
    step(4);
    btn_n[0] = 1'b1;
    expect_ev(cyc + LAT, EV_RELEASE, 0);
    step(12);
  endtask

  task automatic test_heartbeat();
    logic prev;
    int   last, toggles;
    prev    = bus0.heartbeat;
    last    = -1;
    toggles = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (bus0.heartbeat !== prev) begin
        toggles++;
        if (last >= 0) begin
          vectors++;
          if (cyc - last !== HB) begin
            miscompares++;
            $display("FAIL heartbeat_half got %0d want %0d", cyc - last, HB);
          end
        end
        last = cyc;
        prev = bus0.heartbeat;
      end
    end
    vectors++;
    if (toggles !== 6) begin
      miscompares++;
      $display("FAIL heartbeat_toggles got %0d want 6", toggles);
    end
  endtask

  task automatic test_multi_channel();
    int t0;
    t0 = cyc;
    btn_n = 4'b0000;
    for (int c = 0; c < CH; c++) expect_ev(t0 + LAT, EV_PRESS, c);
    step(LAT);
    vectors++;
    if (bus0.press_pulse !== 4'b1111) begin
      miscompares++;
      $display("FAIL multi_press got pr=%b want 1111", bus0.press_pulse);
    end
    step(4);
    btn_n = 4'b1111;
    for (int c = 0; c < CH; c++) expect_ev(t0 + 10 + LAT, EV_RELEASE, c);
    step(LAT);
    vectors++;
    if (bus0.release_pulse !== 4'b1111) begin
      miscompares++;
      $display("FAIL multi_release got rl=%b want 1111", bus0.release_pulse);
    end
    step(10);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_collision();
    test_reset_mid_hold();
    test_heartbeat();
    test_multi_channel();
    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
